// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings, FSM states
// and the byte-lane helpers used for store merge and load extension.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Unsigned loads have no store counterpart.
  function automatic logic f3_ok(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return lo[0];
      F3_W:        return lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] align_down(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return {lo[1], 1'b0};
      F3_W:        return 2'b00;
      default:     return lo;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_B:    return 4'b0001 << lo;
      F3_H:    return lo[1] ? 4'b1100 : 4'b0011;
      F3_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate the right-aligned store data across every lane; byte_en picks the live ones.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3)
      F3_B:    return {4{wdata[7:0]}};
      F3_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] word,
                                           input logic [1:0] lo);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = word >> {lo, 3'b000};
    b       = shifted[7:0];
    h       = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'h0, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'h0, h};
      F3_W:    return word;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the core's LSU (master)
// and the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Word-wide single-port synchronous RAM with per-byte write enables and a
// registered read port.
module dmem_array #(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  input  logic          rd,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  // NOTE: storage and its read register carry no reset so this maps onto block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (rd) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store, programmable latency.
// Optional build macro DMEM_MISALIGN_TRAP_EN turns misaligned accesses into errors
// instead of silently aligning them down.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input logic               clk,
  input logic               reset,
  dmem_responder_if.slave   bus
);

  localparam bit DIRECT = (LATENCY == 1);

  state_t            state;
  logic [3:0]        cnt;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        lane_q;

  logic              accept;
  logic              enter_resp;
  logic              a_we;
  logic [2:0]        a_f3;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_err;
  logic [1:0]        a_lo;
  logic [3:0]        ram_be;
  logic              ram_rd;
  logic [31:0]       ram_rdata;

  assign accept     = bus.req_valid && req_ready_q;
  assign enter_resp = (state == WAIT && cnt == 4'd1) || (DIRECT && accept);

  // With single-cycle latency the access happens on the accept edge, so the
  // live request is used; otherwise the captured copy is.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    a_we    = we_q;
    a_f3    = f3_q;
    a_addr  = addr_q;
    a_wdata = wdata_q;
    if (DIRECT) begin
      a_we    = bus.req_we;
      a_f3    = bus.req_funct3;
      a_addr  = bus.req_addr;
      a_wdata = bus.req_wdata;
    end
`ifdef DMEM_MISALIGN_TRAP_EN
    a_err = !f3_ok(a_we, a_f3) || misaligned(a_f3, a_addr[1:0]);
    a_lo  = a_addr[1:0];
`else
    a_err = !f3_ok(a_we, a_f3);
    a_lo  = align_down(a_f3, a_addr[1:0]);
`endif
    ram_be = 4'b0000;
    ram_rd = 1'b0;
    if (enter_resp && !a_err) begin
      ram_be = a_we ? byte_en(a_f3, a_lo) : 4'b0000;
      ram_rd = !a_we;
    end
  end

  dmem_array #(.AW(ADDR_W - 2)) u_array (
    .clk   (clk),
    .addr  (a_addr[ADDR_W-1:2]),
    .be    (ram_be),
    .wdata (store_lanes(a_f3, a_wdata)),
    .rd    (ram_rd),
    .rdata (ram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      lane_q       <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q        <= bus.req_we;
            f3_q        <= bus.req_funct3;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            req_ready_q <= 1'b0;
            if (DIRECT) begin
              state        <= RESP;
              cnt          <= 4'd0;
              resp_valid_q <= 1'b1;
              resp_err_q   <= a_err;
              lane_q       <= a_lo;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= a_err;
            lane_q       <= a_lo;
          end
        end
        RESP: begin
          if (resp_valid_q && bus.resp_ready) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;

  // The RAM read register only updates on entry to RESP, so this stays stable under backpressure.
  always_comb begin
    bus.resp_rdata = '0;
    if (resp_valid_q && !resp_err_q && !we_q) bus.resp_rdata = load_ext(f3_q, ram_rdata, lane_q);
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder with hand sequences for
// backpressure and mid-transaction reset.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(9), .DATA_W(32)) bus ();

  dmem_responder #(.ADDR_W(9), .DATA_W(32), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one request with resp_ready high; returns data, error and the number of
  // cycles from the accept cycle to the first cycle showing resp_valid.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat, output logic rdy);
    int n;
    bus.resp_ready = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    n = 0;
    rdata = 32'h0; err = 1'b0; rdy = 1'b1;
    while (1) begin
      @(negedge clk);
      n++;
      if (bus.resp_valid) break;
      if (n > 20) begin
        check("resp_valid_timeout", 32'(n), 32'(LAT));
        break;
      end
    end
    lat   = n;
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    rdy   = bus.req_ready;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd, held;
    logic        er, rdy;
    int          lat;

    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, held;
    logic        er, rdy;
    int          lat;

    reset          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;

    vecs.push_back('{1'b1, F3_W,  9'h010, 32'h8081_82F3, 32'h0000_0000, 1'b0, "sw_010"});
    vecs.push_back('{1'b0, F3_B,  9'h010, 32'h0,         32'hFFFF_FFF3, 1'b0, "lb_010"});
    vecs.push_back('{1'b0, F3_BU, 9'h013, 32'h0,         32'h0000_0080, 1'b0, "lbu_013"});
    vecs.push_back('{1'b0, F3_H,  9'h012, 32'h0,         32'hFFFF_8081, 1'b0, "lh_012"});
    vecs.push_back('{1'b0, F3_HU, 9'h012, 32'h0,         32'h0000_8081, 1'b0, "lhu_012"});
    vecs.push_back('{1'b0, F3_W,  9'h010, 32'h0,         32'h8081_82F3, 1'b0, "lw_010"});
    vecs.push_back('{1'b1, F3_B,  9'h011, 32'hFFFF_FFAA, 32'h0000_0000, 1'b0, "sb_011"});
    vecs.push_back('{1'b0, F3_W,  9'h010, 32'h0,         32'h8081_AAF3, 1'b0, "lw_after_sb"});
`ifdef DMEM_MISALIGN_TRAP_EN
    vecs.push_back('{1'b0, F3_H,  9'h011, 32'h0,         32'h0000_0000, 1'b1, "lh_011_mis"});
`else
    vecs.push_back('{1'b0, F3_H,  9'h011, 32'h0,         32'hFFFF_AAF3, 1'b0, "lh_011_mis"});
`endif
    vecs.push_back('{1'b0, 3'b011, 9'h010, 32'h0,        32'h0000_0000, 1'b1, "ld_bad_f3"});
    vecs.push_back('{1'b1, F3_BU, 9'h010, 32'h0,         32'h0000_0000, 1'b1, "st_bad_f3"});
    vecs.push_back('{1'b0, F3_W,  9'h010, 32'h0,         32'h8081_AAF3, 1'b0, "lw_no_bad_write"});
    vecs.push_back('{1'b1, F3_W,  9'h014, 32'h1122_3344, 32'h0000_0000, 1'b0, "sw_014"});
    vecs.push_back('{1'b1, F3_H,  9'h016, 32'h0000_BEEF, 32'h0000_0000, 1'b0, "sh_016"});
    vecs.push_back('{1'b0, F3_W,  9'h014, 32'h0,         32'hBEEF_3344, 1'b0, "lw_after_sh"});
    vecs.push_back('{1'b0, F3_B,  9'h017, 32'h0,         32'hFFFF_FFBE, 1'b0, "lb_017"});
    vecs.push_back('{1'b0, F3_HU, 9'h014, 32'h0,         32'h0000_3344, 1'b0, "lhu_014"});
`ifdef DMEM_MISALIGN_TRAP_EN
    vecs.push_back('{1'b1, F3_W,  9'h015, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, "sw_015_mis"});
    vecs.push_back('{1'b0, F3_W,  9'h014, 32'h0,         32'hBEEF_3344, 1'b0, "lw_after_mis_sw"});
`else
    vecs.push_back('{1'b1, F3_W,  9'h015, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, "sw_015_mis"});
    vecs.push_back('{1'b0, F3_W,  9'h014, 32'h0,         32'hDEAD_BEEF, 1'b0, "lw_after_mis_sw"});
`endif
    vecs.push_back('{1'b1, F3_W,  9'h1FC, 32'hA5A5_0001, 32'h0000_0000, 1'b0, "sw_top"});
    vecs.push_back('{1'b0, F3_W,  9'h1FC, 32'h0,         32'hA5A5_0001, 1'b0, "lw_top"});
    vecs.push_back('{1'b1, F3_W,  9'h020, 32'hCAFE_BABE, 32'h0000_0000, 1'b0, "sw_020"});

    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    check("rst_req_ready",  32'(bus.req_ready),  32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata,      32'h0);
    check("rst_resp_err",   32'(bus.resp_err),   32'd0);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat, rdy);
      check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      check({vecs[i].name, "_err"}, 32'(er), 32'(vecs[i].exp_err));
      check({vecs[i].name, "_latency"}, 32'(lat), 32'(LAT));
      check({vecs[i].name, "_req_ready_busy"}, 32'(rdy), 32'd0);
    end

    // Backpressure: response held 5 cycles while a conflicting store is presented.
    bus.resp_ready = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 9'h010;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.req_we    = 1'b1;
    bus.req_wdata = 32'h0;
    lat = 0;
    while (!bus.resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", 32'(lat), 32'(LAT));
    held = bus.resp_rdata;
    check("bp_rdata", held, 32'h8081_AAF3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid_hold", 32'(bus.resp_valid), 32'd1);
      check("bp_rdata_hold", bus.resp_rdata, held);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_released", 32'(bus.resp_valid), 32'd0);
    do_req(1'b0, F3_W, 9'h010, 32'h0, rd, er, lat, rdy);
    check("bp_no_write", rd, 32'h8081_AAF3);

    // Reset during WAIT aborts a pending store.
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 9'h020;
    bus.req_wdata  = 32'h1234_5678;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("abort_req_ready",  32'(bus.req_ready),  32'd1);
    check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("abort_resp_rdata", bus.resp_rdata,      32'h0);
    check("abort_resp_err",   32'(bus.resp_err),   32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_req(1'b0, F3_W, 9'h020, 32'h0, rd, er, lat, rdy);
    check("abort_no_write", rd, 32'hCAFE_BABE);
    check("abort_err", 32'(er), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
